fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/fifo_wr_ctrl.sv | 95 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray-code helpers, used by both the write-side and read-side controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ASIZE = 4;
  localparam int unsigned FIFO_DSIZE = 8;
  // Helpers work on a fixed wide word; callers zero-extend and slice to pointer width.
  localparam int unsigned FIFO_GW    = 32;

  function automatic logic [FIFO_GW-1:0] bin2gray(input logic [FIFO_GW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [FIFO_GW-1:0] gray2bin(input logic [FIFO_GW-1:0] g);
    logic [FIFO_GW-1:0] b;
    b = '0;
    b[FIFO_GW-1] = g[FIFO_GW-1];
    for (int unsigned i = 2; i <= FIFO_GW; i++) begin
      b[FIFO_GW-i] = b[FIFO_GW-i+1] ^ g[FIFO_GW-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray pointers crossing into the local clock domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: drives an external RAM, keeps the Gray write pointer
// and full/overflow flags. Optional almost_full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ASIZE     = FIFO_ASIZE,
  parameter int unsigned DSIZE     = FIFO_DSIZE,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic [ASIZE:0]   rd_ptr_gray,
  output logic             wr_en,
  output logic [ASIZE-1:0] wr_addr,
  output logic [DSIZE-1:0] wr_data,
  output logic [ASIZE:0]   wr_ptr_gray,
  output logic             full,
`ifdef FIFO_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic             overflow
);

  logic [ASIZE:0]   rq2;
  logic [ASIZE:0]   wbin;
  logic [ASIZE:0]   wbin_next;
  logic [ASIZE:0]   wgray_next;
  logic [FIFO_GW-1:0] wgray_wide;
  logic             full_next;
  logic             unused_gray_hi;

  sync_2ff #(
    .WIDTH (ASIZE + 1)
  ) u_rd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq2)
  );

  assign wr_en   = push & ~full & ~rst;
  assign wr_addr = wbin[ASIZE-1:0];
  assign wr_data = push_data;

  assign wbin_next      = wbin + {{ASIZE{1'b0}}, wr_en};
  assign wgray_wide     = bin2gray(FIFO_GW'(wbin_next));
  assign wgray_next     = wgray_wide[ASIZE:0];
  assign unused_gray_hi = ^wgray_wide[FIFO_GW-1:ASIZE+1];

  // Full when the next write pointer laps the synced read pointer: Gray form flips the top two bits.
  assign full_next = (wgray_next == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      full        <= full_next;
      if (push && full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ASIZE:0] AF_LEVEL = (ASIZE + 1)'((2 ** ASIZE) - AF_MARGIN);

  logic [FIFO_GW-1:0] rbin_wide;
  logic [ASIZE:0]     rbin_s;
  logic [ASIZE:0]     level_next;
  logic               unused_rbin_hi;

  assign rbin_wide      = gray2bin(FIFO_GW'(rq2));
  assign rbin_s         = rbin_wide[ASIZE:0];
  assign unused_rbin_hi = ^rbin_wide[FIFO_GW-1:ASIZE+1];
  assign level_next     = wbin_next - rbin_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (level_next >= AF_LEVEL);
    end
  end
`else
  localparam int unsigned UNUSED_AF_MARGIN = AF_MARGIN;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: reset, fill, overflow, drain release, pointer wrap, mid-burst reset.
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic [4:0] rd_ptr_gray;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  fifo_wr_ctrl #(
    .ASIZE     (4),
    .DSIZE     (8),
    .AF_MARGIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_data),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
`ifdef FIFO_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int unsigned b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int unsigned ones5(input logic [4:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]) + int'(v[4]);
  endfunction

  int unsigned wptr;
  logic [4:0]  prev_gray;

  initial begin
    rst = 1'b1; push = 1'b0; push_data = '0; rd_ptr_gray = '0;
    step();
    push = 1'b1;
    #1 check_eq("wr_en_in_reset", 32'(wr_en), 0);
    step();
    push = 1'b0; rst = 1'b0;
    #1;
    check_eq("idle_wr_en", 32'(wr_en), 0);
    check_eq("idle_wr_addr", 32'(wr_addr), 0);
    check_eq("idle_gray", 32'(wr_ptr_gray), 0);
    check_eq("idle_full", 32'(full), 0);
    check_eq("idle_overflow", 32'(overflow), 0);

    // Fill 16 entries with no reads.
    for (int unsigned i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 8'(i);
      #1;
      check_eq("fill_wr_en", 32'(wr_en), 1);
      check_eq("fill_wr_addr", 32'(wr_addr), i);
      check_eq("fill_wr_data", 32'(wr_data), i);
      check_eq("fill_full_early", 32'(full), 0);
      step();
      check_eq("fill_gray", 32'(wr_ptr_gray), 32'(gray5(i + 1)));
    end
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_gray_final", 32'(wr_ptr_gray), 32'h18);

    // Push while full is dropped and sets overflow.
    push = 1'b1; push_data = 8'hAA;
    #1 check_eq("ovf_wr_en", 32'(wr_en), 0);
    step();
    push = 1'b0;
    check_eq("ovf_flag", 32'(overflow), 1);
    check_eq("ovf_addr_held", 32'(wr_addr), 0);
    check_eq("ovf_gray_held", 32'(wr_ptr_gray), 32'h18);
    step(); step();
    check_eq("ovf_sticky", 32'(overflow), 1);

    // One read frees a slot; a push in that same cycle is still dropped.
    rd_ptr_gray = gray5(1);
    push = 1'b1; push_data = 8'h77;
    #1 check_eq("same_cycle_drop", 32'(wr_en), 0);
    step();
    push = 1'b0;
    check_eq("drain_edge1", 32'(full), 1);
    check_eq("drain_addr_held", 32'(wr_addr), 0);
    step();
    check_eq("drain_edge2", 32'(full), 1);
    step();
    check_eq("drain_edge3", 32'(full), 0);
    push = 1'b1; push_data = 8'h55;
    #1;
    check_eq("drain_wr_en", 32'(wr_en), 1);
    check_eq("drain_wr_addr", 32'(wr_addr), 0);
    step();
    push = 1'b0;
    check_eq("drain_gray", 32'(wr_ptr_gray), 32'h19);
    check_eq("drain_refull", 32'(full), 1);

    // Reader catches up, then 40 writes shadowed by reads across the 31->0 wrap.
    wptr = 17;
    rd_ptr_gray = gray5(wptr);
    step(); step(); step();
    check_eq("wrap_pre_full", 32'(full), 0);
    for (int unsigned i = 0; i < 40; i++) begin
      rd_ptr_gray = gray5(wptr);
      push = 1'b1; push_data = 8'(i);
      prev_gray = wr_ptr_gray;
      #1;
      check_eq("wrap_wr_en", 32'(wr_en), 1);
      check_eq("wrap_wr_addr", 32'(wr_addr), wptr % 16);
      step();
      wptr = (wptr + 1) % 32;
      check_eq("wrap_gray", 32'(wr_ptr_gray), 32'(gray5(wptr)));
      check_eq("wrap_one_bit", ones5(prev_gray ^ wr_ptr_gray), 1);
      check_eq("wrap_full", 32'(full), 0);
    end
    push = 1'b0;
    check_eq("wrap_ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of a burst discards that cycle's push.
    push = 1'b1; push_data = 8'hC3; rst = 1'b1; rd_ptr_gray = '0;
    #1 check_eq("rst_mid_wr_en", 32'(wr_en), 0);
    step();
    push = 1'b0; rst = 1'b0;
    check_eq("rst_gray", 32'(wr_ptr_gray), 0);
    check_eq("rst_addr", 32'(wr_addr), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    step(); step();

`ifdef FIFO_ALMOST_FULL_EN
    check_eq("af_idle", 32'(almost_full), 0);
    for (int unsigned i = 0; i < 15; i++) begin
      push = 1'b1; push_data = 8'(i);
      step();
      if (i == 12) check_eq("af_13", 32'(almost_full), 0);
      if (i == 13) begin
        check_eq("af_14", 32'(almost_full), 1);
        check_eq("af_14_full", 32'(full), 0);
      end
    end
    push = 1'b0;
    check_eq("af_15", 32'(almost_full), 1);
    check_eq("af_15_full", 32'(full), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
